// File: rtl/serial_tx_scheduler.sv
// -----------------------------------------------------------------------------
// serial_tx_scheduler
//   Arbitrates four parallel requesters onto one serial line. It uses
//   round-robin arbitration and sends each granted request as a frame:
//     start(0) | port id (2b, MSB first) | length N (LEN_W b, MSB first)
//     | data[N-1:0] (MSB first) | stop(1)
//   Every state change happens on a rising clk edge where clkEn=1.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active high, takes priority over clkEn
//   clkEn        bit-rate enable
//   req[3:0]     per-requester request, held high until that requester's ack
//   len_in       per-requester length, lane i = [LEN_W*i +: LEN_W]
//   data_in      per-requester data,   lane i = [DATA_W*i +: DATA_W]
//   SerOut       serial line, idles at 1
//   SerOutValid  high while a data bit is on SerOut
//   busy         high from START through STOP
//   grant_id     requester being served; keeps its last value while idle
//   ack[3:0]     one-hot, one-clk pulse at the end of the served frame
//   Done         one-clk pulse, coincident with ack
// -----------------------------------------------------------------------------
module serial_tx_scheduler #(
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned DATA_W = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clkEn,
  input  logic [3:0]          req,
  input  logic [4*LEN_W-1:0]  len_in,
  input  logic [4*DATA_W-1:0] data_in,
  output logic                SerOut,
  output logic                SerOutValid,
  output logic                busy,
  output logic [1:0]          grant_id,
  output logic [3:0]          ack,
  output logic                Done
);

  localparam int unsigned NREQ   = 4;
  localparam int unsigned ID_W   = 2;
  localparam int unsigned CNT_W  = LEN_W;
  localparam int unsigned LIDX_W = $clog2(LEN_W);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_PORT  = 3'd2,
    S_LEN   = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic [ID_W-1:0]     prio_q, prio_d;

  logic                ser_q, ser_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic                done_q, done_d;

  logic                win_found;
  logic [ID_W-1:0]     win_id;
  logic [ID_W-1:0]     cand;
  logic [LEN_W-1:0]    win_len;
  logic [DATA_W-1:0]   win_data;

  // Round-robin search: check prio, prio+1, prio+2, prio+3 (mod 4)
  always_comb begin
    win_found = 1'b0;
    win_id    = prio_q;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = prio_q + ID_W'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // Select the winner's length/data lanes
  always_comb begin
    win_len  = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (ID_W'(i) == win_id) begin
        win_len  = len_in[i*LEN_W +: LEN_W];
        win_data = data_in[i*DATA_W +: DATA_W];
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      grant_q <= '0;
      prio_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
    end
  end

  // Next-state logic; bit counter counts down to 0 within each field
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    data_d  = data_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    if (clkEn) begin
      unique case (state_q)
        S_IDLE: begin
          if (win_found) begin
            state_d = S_START;
            grant_d = win_id;
            len_d   = win_len;
            data_d  = win_data;
          end
        end
        S_START: begin
          state_d = S_PORT;
          cnt_d   = CNT_W'(ID_W - 1);
        end
        S_PORT: begin
          if (cnt_q == '0) begin
            state_d = S_LEN;
            cnt_d   = CNT_W'(LEN_W - 1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_LEN: begin
          if (cnt_q == '0) begin
            if (len_q != '0) begin
              state_d = S_DATA;
              cnt_d   = len_q - LEN_W'(1);
            end else begin
              state_d = S_STOP;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == '0) begin
            state_d = S_STOP;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_STOP: begin
          state_d = S_IDLE;
          prio_d  = grant_q + ID_W'(1);
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Output logic: the registered line level reflects the state being entered
  always_comb begin
    ser_d   = ser_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    ack_d   = '0;
    done_d  = 1'b0;
    if (clkEn) begin
      unique case (state_d)
        S_IDLE:  ser_d = 1'b1;
        S_START: ser_d = 1'b0;
        S_PORT:  ser_d = grant_d[cnt_d[0]];
        S_LEN:   ser_d = len_d[cnt_d[LIDX_W-1:0]];
        S_DATA:  ser_d = data_d[cnt_d];
        S_STOP:  ser_d = 1'b1;
        default: ser_d = 1'b1;
      endcase
      valid_d = (state_d == S_DATA);
      busy_d  = (state_d != S_IDLE);
      if (state_q == S_STOP) begin
        ack_d  = NREQ'(1) << grant_q;
        done_d = 1'b1;
      end
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ser_q   <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      ser_q   <= ser_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

  assign SerOut      = ser_q;
  assign SerOutValid = valid_q;
  assign busy        = busy_q;
  assign grant_id    = grant_q;
  assign ack         = ack_q;
  assign Done        = done_q;

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_serial_tx_scheduler
//   Directed bench for serial_tx_scheduler. Each frame is checked bit by bit
//   against hand-built expected bit strings.
// -----------------------------------------------------------------------------
module tb_serial_tx_scheduler;

  localparam int unsigned LEN_W  = 4;
  localparam int unsigned DATA_W = 15;

  logic                clk = 1'b0;
  logic                rst;
  logic                clkEn;
  logic [3:0]          req;
  logic [4*LEN_W-1:0]  len_in;
  logic [4*DATA_W-1:0] data_in;
  logic                SerOut;
  logic                SerOutValid;
  logic                busy;
  logic [1:0]          grant_id;
  logic [3:0]          ack;
  logic                Done;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  serial_tx_scheduler #(.LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .clkEn       (clkEn),
    .req         (req),
    .len_in      (len_in),
    .data_in     (data_in),
    .SerOut      (SerOut),
    .SerOutValid (SerOutValid),
    .busy        (busy),
    .grant_id    (grant_id),
    .ack         (ack),
    .Done        (Done)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clk cycle with the given enable; outputs sampled 1 time unit after the edge
  task automatic tick(input logic en);
    clkEn = en;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_lane(input int i, input logic [LEN_W-1:0] l, input logic [DATA_W-1:0] d);
    len_in[i*LEN_W +: LEN_W]    = l;
    data_in[i*DATA_W +: DATA_W] = d;
  endtask

  // Run a full frame at clkEn=1 and check every bit plus the closing ack edge.
  // With scramble set, inputs change and req drops right after the grant.
  task automatic run_frame(input string tag, input logic [31:0] bits, input int n,
                           input int vstart, input int vcnt, input logic [1:0] gid,
                           input bit scramble);
    logic [3:0] exp_ack;
    for (int i = 0; i < n; i++) begin
      tick(1'b1);
      if (i == 0) begin
        chk($sformatf("%s grant", tag), 32'(grant_id), 32'(gid));
        if (scramble) begin
          len_in  = '1;
          data_in = '1;
          req     = 4'b0000;
        end
      end
      chk($sformatf("%s bit%0d ser", tag, i), 32'(SerOut), 32'(bits[n-1-i]));
      chk($sformatf("%s bit%0d valid", tag, i), 32'(SerOutValid),
          32'((i >= vstart) && (i < vstart + vcnt)));
      chk($sformatf("%s bit%0d busy", tag, i), 32'(busy), 32'd1);
      chk($sformatf("%s bit%0d ack", tag, i), 32'(ack), 32'd0);
    end
    tick(1'b1);
    exp_ack = 4'b0001 << gid;
    chk($sformatf("%s ack", tag), 32'(ack), 32'(exp_ack));
    chk($sformatf("%s done", tag), 32'(Done), 32'd1);
    chk($sformatf("%s idle busy", tag), 32'(busy), 32'd0);
    chk($sformatf("%s idle ser", tag), 32'(SerOut), 32'd1);
  endtask

  initial begin
    int         order [7];
    logic [31:0] b;
    logic [1:0]  gid;
    logic        dbit;
    int          c0;
    logic [9:0]  sbits;

    rst     = 1'b1;
    clkEn   = 1'b1;
    req     = 4'b0000;
    len_in  = '0;
    data_in = '0;
    tick(1'b1);
    tick(1'b1);
    rst = 1'b0;

    // Reset state
    chk("rst ser", 32'(SerOut), 32'd1);
    chk("rst valid", 32'(SerOutValid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst grant", 32'(grant_id), 32'd0);
    chk("rst ack", 32'(ack), 32'd0);
    chk("rst done", 32'(Done), 32'd0);

    // Single requester: len 3, data 101
    set_lane(0, 4'd3, 15'b101);
    req = 4'b0001;
    run_frame("single", 32'b00000111011, 11, 7, 3, 2'd0, 1'b0);
    req = 4'b0000;
    tick(1'b1);
    chk("single ack clear", 32'(ack), 32'd0);
    chk("single done clear", 32'(Done), 32'd0);
    chk("single idle hold", 32'(SerOut), 32'd1);

    // Zero length on requester 2
    set_lane(2, 4'd0, 15'h7FFF);
    req = 4'b0100;
    run_frame("zero", 32'b01000001, 8, 0, 0, 2'd2, 1'b0);
    req = 4'b0000;

    // Round-robin from a fresh reset (prio 0)
    rst = 1'b1;
    tick(1'b1);
    rst = 1'b0;
    set_lane(0, 4'd1, 15'd1);
    set_lane(1, 4'd1, 15'd0);
    set_lane(2, 4'd1, 15'd1);
    set_lane(3, 4'd1, 15'd0);
    order = '{0, 1, 2, 3, 0, 1, 0};
    req = 4'b1111;
    for (int k = 0; k < 7; k++) begin
      gid  = 2'(order[k]);
      dbit = (gid == 2'd0) || (gid == 2'd2);
      b    = {23'd0, 1'b0, gid, 4'b0001, dbit, 1'b1};
      run_frame($sformatf("rr%0d", k), b, 9, 7, 1, gid, 1'b0);
      if (k == 5) req = 4'b0011;
    end
    req = 4'b0000;

    // Reset during DATA bit 5 of a 15-bit frame from requester 1 (prio is 1 here)
    set_lane(1, 4'd15, 15'h2AB3);
    req = 4'b0010;
    b = 32'b001111101010;
    for (int i = 0; i < 12; i++) begin
      tick(1'b1);
      chk($sformatf("mrst bit%0d ser", i), 32'(SerOut), 32'(b[11-i]));
      chk($sformatf("mrst bit%0d valid", i), 32'(SerOutValid), 32'(i >= 7));
    end
    rst = 1'b1;
    tick(1'b1);
    rst = 1'b0;
    chk("mrst ser", 32'(SerOut), 32'd1);
    chk("mrst busy", 32'(busy), 32'd0);
    chk("mrst valid", 32'(SerOutValid), 32'd0);
    chk("mrst ack", 32'(ack), 32'd0);
    chk("mrst done", 32'(Done), 32'd0);
    chk("mrst grant", 32'(grant_id), 32'd0);
    req = 4'b0011;
    run_frame("postrst", {23'd0, 1'b0, 2'b00, 4'b0001, 1'b1, 1'b1}, 9, 7, 1, 2'd0, 1'b0);
    req = 4'b0000;

    // clkEn high 1 of 4 cycles, requester 3, len 2, data 10
    set_lane(3, 4'd2, 15'b10);
    req   = 4'b1000;
    sbits = 10'b0110010101;
    c0    = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1);
      if (i == 0) begin
        c0 = cyc;
        chk("str grant", 32'(grant_id), 32'd3);
      end
      chk($sformatf("str bit%0d ser", i), 32'(SerOut), 32'(sbits[9-i]));
      chk($sformatf("str bit%0d valid", i), 32'(SerOutValid), 32'((i == 7) || (i == 8)));
      for (int j = 0; j < 3; j++) begin
        tick(1'b0);
        chk($sformatf("str bit%0d hold%0d", i, j), 32'(SerOut), 32'(sbits[9-i]));
        chk($sformatf("str bit%0d ack%0d", i, j), 32'(ack), 32'd0);
      end
    end
    tick(1'b1);
    chk("str ack", 32'(ack), 32'b1000);
    chk("str done", 32'(Done), 32'd1);
    chk("str busy", 32'(busy), 32'd0);
    chk("str span", 32'(cyc - c0), 32'd40);
    req = 4'b0000;
    tick(1'b0);
    chk("str ack clear", 32'(ack), 32'd0);
    chk("str done clear", 32'(Done), 32'd0);

    // Inputs change and req drops right after the grant (prio 0, only req2)
    set_lane(2, 4'd5, 15'b10110);
    req = 4'b0100;
    run_frame("stable", 32'b0100101101101, 13, 7, 5, 2'd2, 1'b1);
    tick(1'b1);
    chk("stable ack clear", 32'(ack), 32'd0);
    chk("stable stays idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
